// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Boot/bench program loader. Accepts instruction-field commands (R-type,
// ADDI, ORI, LUI), encodes each one into a 32-bit MIPS word at acceptance,
// buffers the words in a small FIFO and writes them one after another into
// instruction memory starting at BASE_ADDR.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake
//   cmd_kind            - 0=R-type, 1=ADDI, 2=ORI, 3=LUI
//   rs/rt/rd/shamt/funct/imm - instruction fields
//   mem_we/mem_addr/mem_wdata/mem_ack - memory write request and accept
//   words_written       - number of completed memory writes
//   loader_full         - capacity reached, no further commands accepted
//   warn_zero_dst       - sticky "destination is $zero" warning
//
// Optional feature macro: INSTR_ENC_ZERO_DST_CHECK_EN enables the
// warn_zero_dst check; when undefined warn_zero_dst is tied low.
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_kind,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  loader_full,
    output logic                  warn_zero_dst
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           fifo_mem_q [FIFO_DEPTH];
    logic [31:0]           fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
    logic                  loader_full_q, loader_full_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH:0]   words_written_q, words_written_d;

    logic [31:0]           enc_word;
    logic [31:0]           head_word;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;

    // Ready uses the registered count only, so a same-cycle pop never frees
    // a slot for the push in that cycle.
    assign cmd_ready  = (count_q < DEPTH_C) && (accepted_q < CAPACITY);
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count_q == '0);
    assign head_word  = fifo_mem_q[rd_ptr_q];

    // LUI has no rs operand; the field is forced to zero.
    always_comb begin
        enc_word = 32'h0;
        case (cmd_kind)
            2'd0:    enc_word = {6'h00, rs, rt, rd, shamt, funct};
            2'd1:    enc_word = {6'h08, rs, rt, imm};
            2'd2:    enc_word = {6'h0d, rs, rt, imm};
            default: enc_word = {6'h0f, 5'b0, rt, imm};
        endcase
    end

    // Command FIFO bookkeeping and acceptance counter.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        accepted_d = accepted_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            accepted_d           = accepted_q + (ADDR_WIDTH+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        loader_full_d = loader_full_q | (accepted_d == CAPACITY);
    end

    // Write state machine: WRITE is exactly the state in which mem_we is
    // high, so mem_ack is only looked at there.
    always_comb begin
        state_d         = state_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        words_written_d = words_written_q;
        pop             = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = head_word;
                    mem_addr_d  = BASE_ADDR + (32'(words_written_q) << 2);
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    words_written_d = words_written_q + (ADDR_WIDTH+1)'(1);
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        mem_wdata_d = head_word;
                        mem_addr_d  = BASE_ADDR + (32'(words_written_d) << 2);
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            accepted_q      <= '0;
            loader_full_q   <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= BASE_ADDR;
            mem_wdata_q     <= 32'h0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            accepted_q      <= accepted_d;
            loader_full_q   <= loader_full_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            words_written_q <= words_written_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_written_q;
    assign loader_full   = loader_full_q;

`ifdef INSTR_ENC_ZERO_DST_CHECK_EN
    logic zero_dst;
    logic warn_q, warn_d;

    // SLL $0,$0,0 (rd=0, funct=0) is the canonical NOP and is not flagged.
    always_comb begin
        zero_dst = (cmd_kind == 2'd0) ? ((rd == 5'd0) && (funct != 6'd0))
                                      : (rt == 5'd0);
        warn_d   = warn_q | (push && zero_dst);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn_zero_dst = warn_q;
`else
    assign warn_zero_dst = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef INSTR_ENC_ZERO_DST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd_kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic        valid_a, ready_a, ack_a, we_a, full_a, warn_a;
    logic [31:0] addr_a, wdata_a;
    logic [8:0]  ww_a;

    logic        valid_b, ready_b, ack_b, we_b, full_b, warn_b;
    logic [31:0] addr_b, wdata_b;
    logic [2:0]  ww_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_data[$];
    logic [31:0] obs_addr[$];
    int          obs_cyc[$];
    bit          exp_warn;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    instr_encoder_loader dut (
        .clk(clk), .reset(reset),
        .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_kind(cmd_kind),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_ack(ack_a),
        .words_written(ww_a), .loader_full(full_a), .warn_zero_dst(warn_a)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) dut_cap (
        .clk(clk), .reset(reset),
        .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_kind(cmd_kind),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_ack(ack_b),
        .words_written(ww_b), .loader_full(full_b), .warn_zero_dst(warn_b)
    );

    // Reference encoding built from the instruction-format field positions.
    function automatic logic [31:0] model_encode(input cmd_t c);
        logic [31:0] w;
        case (c.kind)
            2'd0: w = (32'(c.rs) << 21) | (32'(c.rt) << 16) | (32'(c.rd) << 11)
                      | (32'(c.shamt) << 6) | 32'(c.funct);
            2'd1: w = (32'd8 << 26) | (32'(c.rs) << 21) | (32'(c.rt) << 16) | 32'(c.imm);
            2'd2: w = (32'd13 << 26) | (32'(c.rs) << 21) | (32'(c.rt) << 16) | 32'(c.imm);
            default: w = (32'd15 << 26) | (32'(c.rt) << 16) | 32'(c.imm);
        endcase
        return w;
    endfunction

    function automatic bit model_zero_dst(input cmd_t c);
        bit hit;
        hit = (c.kind == 2'd0) ? (c.rd == 5'd0 && c.funct != 6'd0) : (c.rt == 5'd0);
        return CHECK_EN && hit;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.kind  = 2'($urandom_range(0, 3));
        c.rs    = 5'($urandom);
        c.rt    = 5'($urandom);
        c.rd    = 5'($urandom);
        c.shamt = 5'($urandom);
        c.funct = 6'($urandom);
        c.imm   = 16'($urandom);
        return c;
    endfunction

    function automatic cmd_t mk(input logic [1:0] k, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                                input logic [15:0] i);
        cmd_t c;
        c.kind = k; c.rs = s; c.rt = t; c.rd = d; c.shamt = sh; c.funct = f; c.imm = i;
        return c;
    endfunction

    // Monitor for the default instance: model of accepted commands and a
    // record of every completed write.
    always @(negedge clk) begin
        cmd_t cur;
        if (reset) begin
            exp_q.delete();
            obs_data.delete();
            obs_addr.delete();
            obs_cyc.delete();
            exp_warn = 1'b0;
        end else begin
            cur.kind = cmd_kind; cur.rs = rs; cur.rt = rt; cur.rd = rd;
            cur.shamt = shamt; cur.funct = funct; cur.imm = imm;
            if (valid_a && ready_a) begin
                exp_q.push_back(model_encode(cur));
                if (model_zero_dst(cur)) exp_warn = 1'b1;
            end
            if (we_a && ack_a) begin
                obs_data.push_back(wdata_a);
                obs_addr.push_back(addr_a);
                obs_cyc.push_back(cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_kind = c.kind; rs = c.rs; rt = c.rt; rd = c.rd;
        shamt = c.shamt; funct = c.funct; imm = c.imm;
    endtask

    task automatic do_reset();
        valid_a = 1'b0; valid_b = 1'b0; ack_a = 1'b1; ack_b = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_a(input cmd_t c);
        bit done;
        done = 1'b0;
        drive_cmd(c);
        valid_a = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ready_a) done = 1'b1;
            tick();
        end
        valid_a = 1'b0;
        if (!done) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL send_timeout: command not accepted within 50 cycles");
        end
    endtask

    task automatic wait_obs(input int n, input int budget);
        int c;
        c = 0;
        while (obs_data.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (obs_data.size() < n) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL write_timeout: got %0d writes, required %0d", obs_data.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; ack_a = 1'b1; ack_b = 1'b1;
        drive_cmd(mk(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0));
        tick();
        @(negedge clk);
        tests_run++; if (we_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we: got %b required 0", we_a); end
        tests_run++; if (addr_a !== BASE) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h required %h", addr_a, BASE); end
        tests_run++; if (wdata_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_wdata: got %h required 0", wdata_a); end
        tests_run++; if (ww_a !== 9'd0) begin tests_failed++; $display("[TB] FAIL reset_words: got %0d required 0", ww_a); end
        tests_run++; if (full_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %b required 0", full_a); end
        tests_run++; if (warn_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_warn: got %b required 0", warn_a); end
        tests_run++; if (ready_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b required 1", ready_a); end
        tests_run++; if (ww_b !== 3'd0 || full_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cap: words %0d full %b required 0 0", ww_b, full_b); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int pulses;
        logic [31:0] d, a;
        do_reset();
        pulses = 0; d = '0; a = '0;
        send_a(mk(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (we_a) begin
                if (pulses == 0) begin d = wdata_a; a = addr_a; end
                pulses++;
            end
        end
        tests_run++; if (pulses != 1) begin tests_failed++; $display("[TB] FAIL basic_pulse: got %0d cycles required 1", pulses); end
        tests_run++; if (d !== 32'h2008_0005) begin tests_failed++; $display("[TB] FAIL basic_wdata: got %h required 20080005", d); end
        tests_run++; if (a !== BASE) begin tests_failed++; $display("[TB] FAIL basic_addr: got %h required %h", a, BASE); end
        tests_run++; if (ww_a !== 9'd1) begin tests_failed++; $display("[TB] FAIL basic_words: got %0d required 1", ww_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3];
        want[0] = 32'h012A_5820; want[1] = 32'h3409_00FF; want[2] = 32'h3C01_1234;
        do_reset();
        send_a(mk(2'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h20, 16'h0));
        send_a(mk(2'd2, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 16'h00ff));
        send_a(mk(2'd3, 5'd7, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234));
        wait_obs(3, 20);
        if (obs_data.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (obs_data[i] !== want[i]) begin tests_failed++; $display("[TB] FAIL b2b_wdata[%0d]: got %h required %h", i, obs_data[i], want[i]); end
                tests_run++;
                if (obs_addr[i] !== BASE + 32'(4 * i)) begin tests_failed++; $display("[TB] FAIL b2b_addr[%0d]: got %h required %h", i, obs_addr[i], BASE + 32'(4 * i)); end
            end
            tests_run++;
            if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
                tests_failed++; $display("[TB] FAIL b2b_consecutive: cycles %0d %0d %0d required consecutive", obs_cyc[0], obs_cyc[1], obs_cyc[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        cmd_t cmds [6];
        int idx, unstable;
        bit held;
        logic [31:0] h_addr, h_data;
        do_reset();
        for (int i = 0; i < 6; i++) cmds[i] = rand_cmd();
        ack_a = 1'b0; idx = 0; unstable = 0; held = 1'b0; h_addr = '0; h_data = '0;
        for (int c = 0; c < 10; c++) begin
            valid_a = (idx < 6);
            if (idx < 6) drive_cmd(cmds[idx]);
            @(negedge clk);
            if (valid_a && ready_a) idx++;
            if (held) begin
                if (we_a !== 1'b1 || addr_a !== h_addr || wdata_a !== h_data) unstable++;
            end else if (we_a) begin
                held = 1'b1; h_addr = addr_a; h_data = wdata_a;
            end
            tick();
        end
        valid_a = 1'b0;
        @(negedge clk);
        tests_run++; if (idx != 5) begin tests_failed++; $display("[TB] FAIL bp_accepted: got %0d required 5", idx); end
        tests_run++; if (ready_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready: got %b required 0", ready_a); end
        tests_run++; if (!held || unstable != 0) begin tests_failed++; $display("[TB] FAIL bp_stable: held %b changes %0d required 1 0", held, unstable); end
        tests_run++; if (ww_a !== 9'd0) begin tests_failed++; $display("[TB] FAIL bp_words_held: got %0d required 0", ww_a); end
        tick();
        ack_a = 1'b1;
        if (idx < 6) send_a(cmds[5]);
        wait_obs(6, 40);
        if (obs_data.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (obs_data[i] !== model_encode(cmds[i]) || obs_addr[i] !== BASE + 32'(4 * i)) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_order[%0d]: got %h@%h required %h@%h", i, obs_data[i], obs_addr[i], model_encode(cmds[i]), BASE + 32'(4 * i));
                end
            end
        end
        tick();
        tests_run++; if (ww_a !== 9'd6) begin tests_failed++; $display("[TB] FAIL bp_words: got %0d required 6", ww_a); end
    endtask

    task automatic test_capacity();
        cmd_t cmds [6];
        int idx, writes, ready_late;
        logic [31:0] last_addr, last_data;
        do_reset();
        for (int i = 0; i < 6; i++) cmds[i] = rand_cmd();
        idx = 0; writes = 0; ready_late = 0; last_addr = '0; last_data = '0;
        ack_b = 1'b1;
        for (int c = 0; c < 16; c++) begin
            valid_b = (idx < 6);
            drive_cmd(cmds[(idx < 6) ? idx : 5]);
            @(negedge clk);
            if (idx >= 4 && ready_b) ready_late++;
            if (valid_b && ready_b) idx++;
            if (we_b) begin writes++; last_addr = addr_b; last_data = wdata_b; end
            tick();
        end
        valid_b = 1'b0;
        @(negedge clk);
        tests_run++; if (idx != 4) begin tests_failed++; $display("[TB] FAIL cap_accepted: got %0d required 4", idx); end
        tests_run++; if (ready_late != 0 || ready_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL cap_ready: late-ready cycles %0d ready %b required 0 0", ready_late, ready_b); end
        tests_run++; if (full_b !== 1'b1) begin tests_failed++; $display("[TB] FAIL cap_full: got %b required 1", full_b); end
        tests_run++; if (last_addr !== BASE + 32'hC) begin tests_failed++; $display("[TB] FAIL cap_last_addr: got %h required %h", last_addr, BASE + 32'hC); end
        tests_run++; if (last_data !== model_encode(cmds[3])) begin tests_failed++; $display("[TB] FAIL cap_last_data: got %h required %h", last_data, model_encode(cmds[3])); end
        tests_run++; if (ww_b !== 3'd4 || writes != 4) begin tests_failed++; $display("[TB] FAIL cap_words: got %0d (pulses %0d) required 4", ww_b, writes); end
        tick();
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        int stray;
        do_reset();
        ack_a = 1'b0;
        for (int i = 0; i < 3; i++) send_a(rand_cmd());
        tick();
        @(negedge clk);
        tests_run++; if (we_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_pre_we: got %b required 1", we_a); end
        tick();
        reset = 1'b1; ack_a = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if (we_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_we: got %b required 0", we_a); end
        tests_run++; if (ww_a !== 9'd0) begin tests_failed++; $display("[TB] FAIL rmid_words: got %0d required 0", ww_a); end
        tests_run++; if (addr_a !== BASE) begin tests_failed++; $display("[TB] FAIL rmid_addr: got %h required %h", addr_a, BASE); end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (we_a) stray++;
        end
        tests_run++; if (stray != 0) begin tests_failed++; $display("[TB] FAIL rmid_discard: got %0d write cycles required 0", stray); end
        tick();
        c = rand_cmd();
        send_a(c);
        wait_obs(1, 10);
        if (obs_data.size() >= 1) begin
            tests_run++;
            if (obs_data[0] !== model_encode(c) || obs_addr[0] !== BASE) begin
                tests_failed++; $display("[TB] FAIL rmid_next: got %h@%h required %h@%h", obs_data[0], obs_addr[0], model_encode(c), BASE);
            end
        end
    endtask

    task automatic test_random();
        cmd_t cur;
        int sent, budget;
        do_reset();
        sent = 0; budget = 0;
        cur = rand_cmd();
        while ((sent < 40 || obs_data.size() < exp_q.size()) && budget < 600) begin
            valid_a = (sent < 40) && ($urandom_range(0, 3) != 0);
            ack_a   = (sent >= 40) || ($urandom_range(0, 2) != 0);
            drive_cmd(cur);
            @(negedge clk);
            if (valid_a && ready_a) begin sent++; cur = rand_cmd(); end
            tick();
            budget++;
        end
        valid_a = 1'b0; ack_a = 1'b1;
        tick();
        @(negedge clk);
        tests_run++; if (sent != 40 || obs_data.size() != 40 || exp_q.size() != 40) begin
            tests_failed++; $display("[TB] FAIL rand_count: sent %0d written %0d modelled %0d required 40", sent, obs_data.size(), exp_q.size());
        end
        if (obs_data.size() == exp_q.size()) begin
            for (int i = 0; i < obs_data.size(); i++) begin
                tests_run++;
                if (obs_data[i] !== exp_q[i] || obs_addr[i] !== BASE + 32'(4 * i)) begin
                    tests_failed++; $display("[TB] FAIL rand_word[%0d]: got %h@%h required %h@%h", i, obs_data[i], obs_addr[i], exp_q[i], BASE + 32'(4 * i));
                end
            end
        end
        tests_run++; if (ww_a !== 9'(obs_data.size())) begin tests_failed++; $display("[TB] FAIL rand_words: got %0d required %0d", ww_a, obs_data.size()); end
        tests_run++; if (warn_a !== exp_warn) begin tests_failed++; $display("[TB] FAIL rand_warn: got %b required %b", warn_a, exp_warn); end
    endtask

    task automatic test_zero_dst();
        cmd_t c;
        do_reset();
        send_a(mk(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0));
        repeat (3) tick();
        @(negedge clk);
        tests_run++; if (warn_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL zd_nop: got %b required 0", warn_a); end
        c = mk(2'd1, 5'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'h1234);
        send_a(c);
        repeat (3) tick();
        @(negedge clk);
        tests_run++; if (warn_a !== CHECK_EN) begin tests_failed++; $display("[TB] FAIL zd_addi: got %b required %b", warn_a, CHECK_EN); end
        tests_run++;
        if (obs_data.size() < 2 || obs_data[obs_data.size()-1] !== model_encode(c)) begin
            tests_failed++; $display("[TB] FAIL zd_word: writes %0d, required last word %h", obs_data.size(), model_encode(c));
        end
        send_a(mk(2'd2, 5'd1, 5'd5, 5'd0, 5'd0, 6'd0, 16'h00aa));
        repeat (3) tick();
        @(negedge clk);
        tests_run++; if (warn_a !== CHECK_EN) begin tests_failed++; $display("[TB] FAIL zd_sticky: got %b required %b", warn_a, CHECK_EN); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_capacity();
        test_reset_mid();
        test_random();
        test_zero_dst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
